// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the PC fetch sequencer.
//   state_t        : sequencer states BOOT, FETCH, STALL, HALTED
//   INST_BYTES     : instruction size in bytes (PC step)
//   DEFAULT_ADDR_W : default PC / fetch address width
package pc_seq_pkg;
   typedef enum logic [1:0] {BOOT, FETCH, STALL, HALTED} state_t;
   localparam int unsigned INST_BYTES     = 4;
   localparam int unsigned DEFAULT_ADDR_W = 64;
endpackage

// File: rtl/pc_incrementer.sv
// pc_incrementer: combinational sequential-PC adder, wraps modulo 2^ADDR_W.
//   pc   in  ADDR_W  current PC
//   next out ADDR_W  pc + INST_BYTES
module pc_incrementer
   import pc_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] next
);
   assign next = pc + ADDR_W'(INST_BYTES);
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: holds the PC, issues instruction fetches, advances by
// INST_BYTES per completed fetch, applies branch redirects and squashes
// wrong-path fetches; supports stall and halt/resume.
// Optional build macro PC_MISALIGN_TRAP_EN: a misaligned applied target loads
// TRAP_VECTOR and pulses misalign_trap; otherwise targets are used verbatim.
// Ports:
//   clk, reset (async, active-high)
//   stall, halt_req, resume             : flow control from downstream/control
//   redirect_valid, redirect_target     : taken branch from execute
//   imem_req, imem_addr, imem_ack       : instruction memory handshake
//   inst_valid, inst_pc                 : delivered instruction (1-cycle pulse)
//   pc, halted, misalign_trap           : architectural PC and status
module pc_fetch_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned       ADDR_W       = DEFAULT_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(64'h100)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              halt_req,
   input  logic              resume,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              imem_ack,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              inst_valid,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              misalign_trap
);
   state_t            state, state_nxt;
   logic              redirect_pending;
   logic [ADDR_W-1:0] pending_target;
   logic [ADDR_W-1:0] pc_inc, tgt, tgt_applied, pc_nxt;
   logic              fetching, ack_fetch, squash, take, tgt_bad;

   pc_incrementer #(.ADDR_W(ADDR_W)) u_inc (.pc(pc), .next(pc_inc));

   assign fetching  = (state == FETCH);
   assign imem_req  = fetching;
   assign imem_addr = pc;
   assign halted    = (state == HALTED);

   always_comb begin
      ack_fetch = fetching && imem_ack;
      // A redirect seen with the ack (or captured earlier) makes this fetch wrong-path.
      squash    = ack_fetch && (redirect_pending || redirect_valid);
      // Outside FETCH nothing is pending, so the live target is chosen.
      tgt       = redirect_pending ? pending_target : redirect_target;
      take      = squash || (!fetching && redirect_valid);
`ifdef PC_MISALIGN_TRAP_EN
      tgt_bad   = (tgt[1:0] != 2'b00);
`else
      tgt_bad   = 1'b0;
`endif
      tgt_applied = tgt_bad ? TRAP_VECTOR : tgt;
      pc_nxt      = take ? tgt_applied : ack_fetch ? pc_inc : pc;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = FETCH;
         FETCH:   state_nxt = !imem_ack ? FETCH : halt_req ? HALTED : stall ? STALL : FETCH;
         STALL:   state_nxt = halt_req ? HALTED : stall ? STALL : FETCH;
         HALTED:  state_nxt = (resume && !halt_req) ? FETCH : HALTED;
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= BOOT;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc               <= RESET_VECTOR;
         inst_valid       <= 1'b0;
         inst_pc          <= '0;
         misalign_trap    <= 1'b0;
         redirect_pending <= 1'b0;
         pending_target   <= '0;
      end else begin
         pc            <= pc_nxt;
         inst_valid    <= ack_fetch && !squash;
         misalign_trap <= take && tgt_bad;
         if (ack_fetch && !squash) inst_pc <= pc;
         // Hold a redirect that arrives mid-fetch until the fetch completes; newest wins.
         redirect_pending <= fetching && !imem_ack && (redirect_valid || redirect_pending);
         if (fetching && !imem_ack && redirect_valid) pending_target <= redirect_target;
      end
   end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed + randomized check of pc_fetch_sequencer
// against a transaction-level reference model.
module tb_pc_fetch_sequencer;
   localparam logic [63:0] RV = 64'h0;
   localparam logic [63:0] TV = 64'h100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0, halt_req = 1'b0, resume = 1'b0;
   logic        redirect_valid = 1'b0, imem_ack = 1'b0;
   logic [63:0] redirect_target = '0;
   logic        imem_req, inst_valid, halted, misalign_trap;
   logic [63:0] imem_addr, inst_pc, pc;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the sequencer is either booting, halted, waiting on a
   // stall, or fetching (none of the others).
   bit          m_boot, m_halt, m_wait, m_valid, m_trap;
   logic [63:0] m_pc, m_ipc;
   logic [63:0] m_pend[$];

   always #5 clk = ~clk;

   pc_fetch_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr),
      .inst_valid(inst_valid), .inst_pc(inst_pc), .pc(pc), .halted(halted),
      .misalign_trap(misalign_trap)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_fetching();
      return !m_boot && !m_halt && !m_wait;
   endfunction

   task automatic m_reset();
      m_boot = 1; m_halt = 0; m_wait = 0; m_valid = 0; m_trap = 0;
      m_pc = RV; m_ipc = '0; m_pend.delete();
   endtask

   task automatic m_jump(input logic [63:0] t);
`ifdef PC_MISALIGN_TRAP_EN
      if (t[1:0] != 2'b00) begin m_pc = TV; m_trap = 1; end
      else m_pc = t;
`else
      m_pc = t;
`endif
   endtask

   task automatic m_step();
      logic [63:0] t;
      m_valid = 0; m_trap = 0;
      if (m_fetching()) begin
         if (!imem_ack) begin
            if (redirect_valid) begin m_pend.delete(); m_pend.push_back(redirect_target); end
         end else begin
            if (m_pend.size() > 0 || redirect_valid) begin
               t = (m_pend.size() > 0) ? m_pend[0] : redirect_target;
               m_pend.delete();
               m_jump(t);
            end else begin
               m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 64'd4;
            end
            if (halt_req) m_halt = 1;
            else if (stall) m_wait = 1;
         end
      end else begin
         if (redirect_valid) m_jump(redirect_target);
         if (m_boot) m_boot = 0;
         else if (m_wait) begin
            if (halt_req) begin m_wait = 0; m_halt = 1; end
            else if (!stall) m_wait = 0;
         end else if (m_halt && resume && !halt_req) m_halt = 0;
      end
   endtask

   task automatic compare();
      check("imem_req", imem_req, m_fetching());
      check("imem_addr", imem_addr, m_pc);
      check("inst_valid", inst_valid, m_valid);
      check("inst_pc", inst_pc, m_ipc);
      check("pc", pc, m_pc);
      check("halted", halted, m_halt);
      check("misalign_trap", misalign_trap, m_trap);
   endtask

   task automatic cyc(input bit st, input bit hr, input bit rs, input bit rv,
                      input logic [63:0] rt, input bit ak);
      stall = st; halt_req = hr; resume = rs; redirect_valid = rv;
      redirect_target = rt; imem_ack = ak;
      @(posedge clk);
      m_step();
      #1 compare();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stall = 0; halt_req = 0; resume = 0; redirect_valid = 0; imem_ack = 0;
      @(posedge clk); #1;
      m_reset();
      reset = 1'b0;
      check("rst_req", imem_req, 1'b0);
      check("rst_pc", pc, RV);
      compare();
   endtask

   initial begin
      logic [63:0] rt;
      do_reset();
      // Back-to-back acks from boot: addresses 0,4,8,C with inst_pc trailing.
      repeat (5) cyc(0, 0, 0, 0, '0, 1);
      check("b2b_pc", pc, 64'h10);
      // Ack withheld three cycles, then given.
      repeat (3) cyc(0, 0, 0, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, 1);
      check("wait_ipc", inst_pc, 64'h10);
      // Redirect captured mid-fetch two cycles before the ack: fetch squashed.
      cyc(0, 0, 0, 1, 64'h40, 0);
      cyc(0, 0, 0, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, 1);
      check("squash_valid", inst_valid, 1'b0);
      check("squash_addr", imem_addr, 64'h40);
      // Stall during ack, release, then halt and resume.
      cyc(1, 0, 0, 0, '0, 1);
      check("stall_req", imem_req, 1'b0);
      cyc(1, 0, 0, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, 0);
      check("stall_resume_addr", imem_addr, 64'h44);
      cyc(0, 1, 0, 0, '0, 1);
      cyc(0, 1, 1, 0, '0, 0);
      check("halt_wins", halted, 1'b1);
      cyc(0, 0, 1, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, 1);
      // Wrap at the top of the address space.
      cyc(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
      cyc(0, 0, 0, 0, '0, 1);
      check("wrap_pc", pc, 64'h0);
      // Misaligned redirect while halted.
      cyc(0, 1, 0, 0, '0, 1);
      cyc(0, 1, 0, 1, 64'h42, 0);
`ifdef PC_MISALIGN_TRAP_EN
      check("misalign_pc", pc, 64'h100);
      check("misalign_trap", misalign_trap, 1'b1);
`else
      check("misalign_pc", pc, 64'h42);
      check("misalign_trap", misalign_trap, 1'b0);
`endif
      cyc(0, 0, 1, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, 0);
      // Asynchronous reset while a request is outstanding.
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("arst_req", imem_req, 1'b0);
      check("arst_pc", pc, RV);
      m_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      compare();
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rt = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
         cyc($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
             $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
             rt, $urandom_range(0, 99) < 60);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
